branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/PC/immediate width (>= 8).
REQ-002 Parameter: CNT_W, default 16, statistics counter width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 inValid  input  1  request valid.
REQ-007 inReady  output  1  unit can accept a request this cycle.
REQ-008 dataIn1, dataIn2  input  XLEN  compare operands (rs1, rs2).
REQ-009 opCode  input  3  branch funct3.
REQ-010 pcIn  input  XLEN  branch instruction PC.
REQ-011 immIn  input  XLEN  sign-extended branch offset.
REQ-012 predTaken  input  1  front-end prediction.
REQ-013 flush  input  1  discard all in-flight requests.
REQ-014 clrCount  input  1  clear statistics counters.
REQ-015 outValid  output  1  result valid.
REQ-016 outReady  input  1  consumer accepts result.
REQ-017 branchOut  output  1  resolved taken.
REQ-018 targetOut  output  XLEN  resolved next PC.
REQ-019 mispredict  output  1  branchOut != predTaken.
REQ-020 branchCount, mispredCount  output  CNT_W  statistics.

Function
REQ-021 opCode encoding: 000 BEQ equal, 001 BNE not equal, 100 BLT signed less, 101 BGE signed greater-or-equal, 110 BLTU unsigned less, 111 BGEU unsigned greater-or-equal; 010/011 resolve not-taken.
REQ-022 Pipeline: two registered stages S1, S2; S1 captures compare result, pcIn, immIn, predTaken on accept; S2 captures branchOut, targetOut, mispredict from S1.
REQ-023 Accept = inValid && inReady; inReady = !rst && !flush && (!s1Valid || s1Advance).
REQ-024 s1Advance = s1Valid && (!s2Valid || outReady); S2 holds all outputs stable while outValid && !outReady.
REQ-025 outValid = s2Valid (registered); latency accept-to-outValid = 2 cycles with no stall; throughput 1/cycle with outReady held high.
REQ-026 targetOut = taken ? pcIn + immIn : pcIn + 4, modulo 2^XLEN (wrap, no overflow flag).
REQ-027 mispredict = taken XOR predTaken; illegal opCode yields taken=0, target pcIn+4.
REQ-028 Counters advance only on output handshake (outValid && outReady): branchCount +1; mispredCount +1 if mispredict.
REQ-029 Counters saturate at 2^CNT_W-1; no wrap.
REQ-030 clrCount zeroes both counters next edge; clrCount beats a same-cycle increment.
REQ-031 flush clears s1Valid and s2Valid at the next edge; no accept in a flush cycle; an output handshake in the flush cycle completes and is counted.
REQ-032 Output data registers are don't-care-free: hold last value when s2Valid=0.

Reset
REQ-033 While rst=1: inReady=0; at the edge s1Valid=s2Valid=0, outValid=0, branchOut=0, targetOut=0, mispredict=0, branchCount=0, mispredCount=0.
REQ-034 rst beats flush, clrCount and any handshake; reset mid-stream drops all in-flight requests.

Verification
REQ-035 BLT dataIn1=0xFFFFFFFF, dataIn2=1, pcIn=0x100, immIn=0x20, predTaken=0 -> 2 cycles later outValid=1, branchOut=1, targetOut=0x120, mispredict=1, mispredCount=1.
REQ-036 BLTU same operands, predTaken=0 -> branchOut=0, targetOut=0x104, mispredict=0; BGEU -> branchOut=1.
REQ-037 Back-to-back 4 requests, outReady=0 for 3 cycles -> inReady=0 after 2 accepts, outputs stable, no loss or reorder after release; branchCount=4.
REQ-038 flush with both stages full, inValid=1 -> no accept, outValid=0 next cycle, counters unchanged.
REQ-039 CNT_W=4, 17 handshakes -> branchCount=15; clrCount with simultaneous handshake -> 0.
REQ-040 pcIn=0xFFFFFFFC, BEQ equal, immIn=8 -> targetOut=0x4; opCode=010 -> branchOut=0, targetOut=pcIn+4.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_if
// Purpose  : Request/result bundle for the branch resolve unit. The front end
//            uses the master view and the resolve unit uses the slave view.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // request side
  logic             inValid;
  logic             inReady;
  logic [XLEN-1:0]  dataIn1;
  logic [XLEN-1:0]  dataIn2;
  logic [2:0]       opCode;
  logic [XLEN-1:0]  pcIn;
  logic [XLEN-1:0]  immIn;
  logic             predTaken;
  // control
  logic             flush;
  logic             clrCount;
  // result side
  logic             outValid;
  logic             outReady;
  logic             branchOut;
  logic [XLEN-1:0]  targetOut;
  logic             mispredict;
  // statistics
  logic [CNT_W-1:0] branchCount;
  logic [CNT_W-1:0] mispredCount;

  modport master (
    output inValid, dataIn1, dataIn2, opCode, pcIn, immIn, predTaken,
    output flush, clrCount, outReady,
    input  inReady, outValid, branchOut, targetOut, mispredict,
    input  branchCount, mispredCount
  );

  modport slave (
    input  inValid, dataIn1, dataIn2, opCode, pcIn, immIn, predTaken,
    input  flush, clrCount, outReady,
    output inReady, outValid, branchOut, targetOut, mispredict,
    output branchCount, mispredCount
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Two-stage conditional branch resolver. S1 registers the compare
//            outcome with PC/offset/prediction; S2 registers the resolved
//            direction, next PC and mispredict flag. Keeps saturating counts
//            of delivered branches and mispredictions.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  branch_resolve_unit_if.slave  bus
);

  localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  // stage 1
  logic             s1_valid_q, s1_valid_d;
  logic             s1_taken_q, s1_taken_d;
  logic             s1_pred_q,  s1_pred_d;
  logic [XLEN-1:0]  s1_pc_q,    s1_pc_d;
  logic [XLEN-1:0]  s1_imm_q,   s1_imm_d;
  // stage 2
  logic             s2_valid_q, s2_valid_d;
  logic             branch_q,   branch_d;
  logic [XLEN-1:0]  target_q,   target_d;
  logic             mispred_q,  mispred_d;
  // statistics
  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             w_taken;
  logic             w_s1_advance;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_hs;
  logic [XLEN-1:0]  w_target;

  // Branch condition from funct3; the two unused encodings resolve not-taken
  always_comb begin
    w_taken = 1'b0;
    case (bus.opCode)
      3'b000:  w_taken = (bus.dataIn1 == bus.dataIn2);
      3'b001:  w_taken = (bus.dataIn1 != bus.dataIn2);
      3'b100:  w_taken = ($signed(bus.dataIn1) <  $signed(bus.dataIn2));
      3'b101:  w_taken = ($signed(bus.dataIn1) >= $signed(bus.dataIn2));
      3'b110:  w_taken = (bus.dataIn1 <  bus.dataIn2);
      3'b111:  w_taken = (bus.dataIn1 >= bus.dataIn2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_s1_advance = s1_valid_q && (!s2_valid_q || bus.outReady);
  assign w_in_ready   = !rst && !bus.flush && (!s1_valid_q || w_s1_advance);
  assign w_accept     = bus.inValid && w_in_ready;
  assign w_out_hs     = s2_valid_q && bus.outReady;
  // next PC wraps modulo 2^XLEN
  assign w_target     = s1_taken_q ? (s1_pc_q + s1_imm_q) : (s1_pc_q + c_PC_STEP);

  // Next-state for both pipeline stages and the statistics counters
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_taken_d    = s1_taken_q;
    s1_pred_d     = s1_pred_q;
    s1_pc_d       = s1_pc_q;
    s1_imm_d      = s1_imm_q;
    s2_valid_d    = s2_valid_q;
    branch_d      = branch_q;
    target_d      = target_q;
    mispred_d     = mispred_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    // S1 occupancy; accept is already blocked in a flush cycle
    if (bus.flush)         s1_valid_d = 1'b0;
    else if (w_accept)     s1_valid_d = 1'b1;
    else if (w_s1_advance) s1_valid_d = 1'b0;

    if (w_accept) begin
      s1_taken_d = w_taken;
      s1_pred_d  = bus.predTaken;
      s1_pc_d    = bus.pcIn;
      s1_imm_d   = bus.immIn;
    end

    // S2 occupancy; data loads are gated by flush so the outputs keep the
    // last delivered result instead of a discarded one
    if (bus.flush)         s2_valid_d = 1'b0;
    else if (w_s1_advance) s2_valid_d = 1'b1;
    else if (w_out_hs)     s2_valid_d = 1'b0;

    if (w_s1_advance && !bus.flush) begin
      branch_d  = s1_taken_q;
      target_d  = w_target;
      mispred_d = s1_taken_q ^ s1_pred_q;
    end

    // A clear wins over a same-cycle increment; counts stick at all-ones
    if (bus.clrCount) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (w_out_hs) begin
      if (branch_cnt_q != c_CNT_MAX)
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispred_q && (mispred_cnt_q != c_CNT_MAX))
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_taken_q    <= 1'b0;
      s1_pred_q     <= 1'b0;
      s1_pc_q       <= '0;
      s1_imm_q      <= '0;
      s2_valid_q    <= 1'b0;
      branch_q      <= 1'b0;
      target_q      <= '0;
      mispred_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_taken_q    <= s1_taken_d;
      s1_pred_q     <= s1_pred_d;
      s1_pc_q       <= s1_pc_d;
      s1_imm_q      <= s1_imm_d;
      s2_valid_q    <= s2_valid_d;
      branch_q      <= branch_d;
      target_q      <= target_d;
      mispred_q     <= mispred_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.inReady      = w_in_ready;
  assign bus.outValid     = s2_valid_q;
  assign bus.branchOut    = branch_q;
  assign bus.targetOut    = target_q;
  assign bus.mispredict   = mispred_q;
  assign bus.branchCount  = branch_cnt_q;
  assign bus.mispredCount = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit
//            (XLEN=32, CNT_W=4 so counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bus.inValid   = 1'b1;
    bus.opCode    = op;
    bus.dataIn1   = a;
    bus.dataIn2   = b;
    bus.pcIn      = pc;
    bus.immIn     = imm;
    bus.predTaken = pred;
  endtask

  // One request into an idle pipeline with outReady high; result checked
  // two edges after the accept edge
  task automatic send_one(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic exp_br, input logic [31:0] exp_tgt,
                          input logic exp_mp);
    @(negedge clk);
    set_req(op, a, b, pc, imm, pred);
    @(negedge clk);
    bus.inValid = 1'b0;
    @(negedge clk);
    check_value({tag, "_vld"}, 32'(bus.outValid), 32'd1);
    check_value({tag, "_br"},  32'(bus.branchOut), 32'(exp_br));
    check_value({tag, "_tgt"}, bus.targetOut, exp_tgt);
    check_value({tag, "_mp"},  32'(bus.mispredict), 32'(exp_mp));
  endtask

  logic [31:0] exp_tgt [4];
  logic        exp_mp  [4];
  logic [31:0] req_pc  [4];
  logic        req_pred[4];
  int          idx;
  int          k;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    bus.inValid  = 1'b0;
    bus.opCode   = 3'b000;
    bus.dataIn1  = '0;
    bus.dataIn2  = '0;
    bus.pcIn     = '0;
    bus.immIn    = '0;
    bus.predTaken = 1'b0;
    bus.flush    = 1'b0;
    bus.clrCount = 1'b0;
    bus.outReady = 1'b1;

    // ---------------- reset state
    @(negedge clk);
    bus.inValid = 1'b1;
    #1;
    check_value("rst_inready", 32'(bus.inReady), 32'd0);
    @(negedge clk);
    check_value("rst_outvalid", 32'(bus.outValid), 32'd0);
    check_value("rst_branch",   32'(bus.branchOut), 32'd0);
    check_value("rst_target",   bus.targetOut, 32'd0);
    check_value("rst_mispred",  32'(bus.mispredict), 32'd0);
    check_value("rst_bcnt",     32'(bus.branchCount), 32'd0);
    check_value("rst_mcnt",     32'(bus.mispredCount), 32'd0);
    bus.inValid = 1'b0;
    rst = 1'b0;

    // ---------------- compare / target for each opcode
    send_one("blt",   3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1);
    @(negedge clk);
    check_value("blt_bcnt", 32'(bus.branchCount), 32'd1);
    check_value("blt_mcnt", 32'(bus.mispredCount), 32'd1);
    check_value("blt_drain", 32'(bus.outValid), 32'd0);
    send_one("bltu",  3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h104, 1'b0);
    send_one("bgeu",  3'b111, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1);
    send_one("beqwr", 3'b000, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b1, 32'h4, 1'b0);
    send_one("op010", 3'b010, 32'd5, 32'd5, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204, 1'b1);
    send_one("bne",   3'b001, 32'd3, 32'd3, 32'h300, 32'h40, 1'b0, 1'b0, 32'h304, 1'b0);
    send_one("bge",   3'b101, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40, 1'b1, 1'b0, 32'h404, 1'b1);
    @(negedge clk);
    check_value("dir_bcnt", 32'(bus.branchCount), 32'd7);
    check_value("dir_mcnt", 32'(bus.mispredCount), 32'd4);

    // ---------------- counter clear
    bus.clrCount = 1'b1;
    @(negedge clk);
    bus.clrCount = 1'b0;
    check_value("clr_bcnt", 32'(bus.branchCount), 32'd0);
    check_value("clr_mcnt", 32'(bus.mispredCount), 32'd0);

    // ---------------- back-to-back with output stall
    for (int i = 0; i < 4; i++) begin
      req_pc[i]   = 32'((i + 1) * 32'h1000);
      req_pred[i] = (i % 2) == 1;
      exp_tgt[i]  = req_pc[i] + 32'h10;
      exp_mp[i]   = !req_pred[i];
    end
    idx = 0;
    k   = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      @(negedge clk);
      bus.outReady = (c >= 4);
      if (bus.outValid) begin
        if (bus.outReady) begin
          check_value("b2b_tgt", bus.targetOut, exp_tgt[k]);
          check_value("b2b_mp",  32'(bus.mispredict), 32'(exp_mp[k]));
          k++;
        end else begin
          check_value("hold_tgt", bus.targetOut, exp_tgt[0]);
          check_value("hold_br",  32'(bus.branchOut), 32'd1);
        end
      end
      if (idx < 4) begin
        set_req(3'b000, 32'd9, 32'd9, req_pc[idx], 32'h10, req_pred[idx]);
        #1;
        if (c == 2 || c == 3) check_value("stall_rdy", 32'(bus.inReady), 32'd0);
        if (bus.inReady) idx++;
      end else begin
        bus.inValid = 1'b0;
      end
    end
    bus.inValid = 1'b0;
    check_value("b2b_count", 32'(k), 32'd4);
    @(negedge clk);
    check_value("b2b_bcnt", 32'(bus.branchCount), 32'd4);
    check_value("b2b_mcnt", 32'(bus.mispredCount), 32'd2);

    // ---------------- flush with both stages full, output stalled
    bus.outReady = 1'b0;
    @(negedge clk);
    set_req(3'b000, 32'd7, 32'd7, 32'h500, 32'h8, 1'b1);
    @(negedge clk);
    set_req(3'b000, 32'd7, 32'd7, 32'h600, 32'h8, 1'b1);
    @(negedge clk);
    set_req(3'b000, 32'd7, 32'd7, 32'h700, 32'h8, 1'b1);
    bus.flush = 1'b1;
    #1;
    check_value("fl_inready", 32'(bus.inReady), 32'd0);
    check_value("fl_full",    32'(bus.outValid), 32'd1);
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.inValid = 1'b0;
    check_value("fl_outvalid", 32'(bus.outValid), 32'd0);
    check_value("fl_hold",     bus.targetOut, 32'h508);
    check_value("fl_bcnt",     32'(bus.branchCount), 32'd4);
    check_value("fl_mcnt",     32'(bus.mispredCount), 32'd2);
    @(negedge clk);
    check_value("fl_empty",    32'(bus.outValid), 32'd0);

    // ---------------- flush while a result is being handed off
    @(negedge clk);
    set_req(3'b000, 32'd7, 32'd7, 32'h500, 32'h8, 1'b1);
    @(negedge clk);
    set_req(3'b000, 32'd7, 32'd7, 32'h600, 32'h8, 1'b1);
    @(negedge clk);
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_value("flhs_outvalid", 32'(bus.outValid), 32'd0);
    check_value("flhs_hold",     bus.targetOut, 32'h508);
    check_value("flhs_bcnt",     32'(bus.branchCount), 32'd5);
    check_value("flhs_mcnt",     32'(bus.mispredCount), 32'd2);

    // ---------------- saturation
    bus.clrCount = 1'b1;
    @(negedge clk);
    bus.clrCount = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_req(3'b001, 32'd1, 32'd2, 32'h800, 32'h40, 1'b0);
      @(negedge clk);
    end
    bus.inValid = 1'b0;
    repeat (3) @(negedge clk);
    check_value("sat_bcnt", 32'(bus.branchCount), 32'd15);
    check_value("sat_mcnt", 32'(bus.mispredCount), 32'd15);
    check_value("sat_tgt",  bus.targetOut, 32'h840);

    // ---------------- reset mid-stream
    bus.outReady = 1'b0;
    set_req(3'b000, 32'd7, 32'd7, 32'h500, 32'h8, 1'b1);
    @(negedge clk);
    set_req(3'b000, 32'd7, 32'd7, 32'h600, 32'h8, 1'b1);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.clrCount = 1'b1;
    rst          = 1'b1;
    #1;
    check_value("mrst_inready", 32'(bus.inReady), 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.clrCount = 1'b0;
    bus.inValid  = 1'b0;
    check_value("mrst_outvalid", 32'(bus.outValid), 32'd0);
    check_value("mrst_target",   bus.targetOut, 32'd0);
    check_value("mrst_bcnt",     32'(bus.branchCount), 32'd0);
    bus.outReady = 1'b1;
    @(negedge clk);
    check_value("mrst_empty",    32'(bus.outValid), 32'd0);

    // ---------------- clear beats simultaneous handshake
    send_one("pre_clr", 3'b110, 32'd1, 32'd2, 32'h700, 32'h10, 1'b1, 1'b1, 32'h710, 1'b0);
    @(negedge clk);
    check_value("pre_clr_bcnt", 32'(bus.branchCount), 32'd1);
    send_one("clr_hs", 3'b110, 32'd1, 32'd2, 32'h700, 32'h10, 1'b0, 1'b1, 32'h710, 1'b1);
    bus.clrCount = 1'b1;
    @(negedge clk);
    bus.clrCount = 1'b0;
    check_value("clrhs_bcnt", 32'(bus.branchCount), 32'd0);
    check_value("clrhs_mcnt", 32'(bus.mispredCount), 32'd0);
    check_value("clrhs_done", 32'(bus.outValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
